// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - round-robin write-back arbiter and RAW/WAW scoreboard for the register file
module rf_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard,
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd3,
  output logic [NREG-1:0] pending
);

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } pri_t;

  pri_t            rr_ptr;
  pri_t            rr_next;
  logic [NREG-1:0] pending_next;

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    rr_next   = rr_ptr;
    if (rst) begin
      if (alu_valid && (!lsu_valid || rr_ptr == PRI_ALU)) begin
        alu_ready = 1'b1;
      end else if (lsu_valid) begin
        lsu_ready = 1'b1;
      end
    end
    if (alu_ready) begin
      rr_next = PRI_LSU;
    end else if (lsu_ready) begin
      rr_next = PRI_ALU;
    end
  end

  // Sources cover RAW, the issuing destination covers WAW; x0 never stalls.
  always_comb begin
    hazard = ((rs1 != '0) && pending[rs1])
           || ((rs2 != '0) && pending[rs2])
           || (iss_valid && (iss_rd != '0) && pending[iss_rd]);
  end

  // Clear applied before set so a same-edge reissue of the written register wins.
  always_comb begin
    pending_next = pending;
    if (rf_we) begin
      pending_next[rf_a3] = 1'b0;
    end
    if (iss_valid && !hazard && (iss_rd != '0)) begin
      pending_next[iss_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr  <= PRI_ALU;
      pending <= '0;
      rf_we   <= 1'b0;
      rf_a3   <= '0;
      rf_wd3  <= '0;
    end else begin
      rr_ptr  <= rr_next;
      pending <= pending_next;
      if (alu_ready) begin
        rf_we  <= (alu_rd != '0);
        rf_a3  <= alu_rd;
        rf_wd3 <= alu_data;
      end else if (lsu_ready) begin
        rf_we  <= (lsu_rd != '0);
        rf_a3  <= lsu_rd;
        rf_wd3 <= lsu_data;
      end else begin
        rf_we  <= 1'b0;
      end
    end
  end

endmodule
